ghost_nav_ctrl: RTL and testbench

Parametrised tile-grid ghost navigator. It replaces per-ghost hard-coded turn tables with a generic wall-aware, target-seeking decision engine. One instance runs per ghost. It owns that ghost's pixel position, advances one tile per `step` pulse, and chooses direction from `tilemap_walls`, a target tile and a behaviour mode. The top level drives `step` from the game tick and feeds each instance's outputs to the renderer and the collision logic.

---
 rtl/ghost_nav_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 tb/tb_ghost_nav_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ghost_nav_ctrl.sv
// ghost_nav_ctrl: one ghost's tile-grid navigator.
// Holds the ghost's pixel position and direction. Each accepted step probes
// the four neighbours (one per cycle, order up/left/down/right), scores the
// open ones by squared distance to the mode's target tile, then moves exactly
// one tile and pulses done.
// Optional feature macro: GHOST_FRIGHT_RANDOM_EN. When it is defined, an 8-bit
// LFSR drives a pseudo-random choice in frightened mode. When it is undefined,
// frightened mode steers exactly like scatter.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for step; outputs hold the current position
// PROBE0   | probe up neighbour
// PROBE1   | probe left neighbour
// PROBE2   | probe down neighbour
// PROBE3   | probe right neighbour
// DECIDE   | resolve best / dead-end / mode-flip reversal / hold
// MOVE     | commit position and direction, pulse done; a step seen here
//          | starts the next decision right away
module ghost_nav_ctrl #(
    parameter int         COLS        = 32,
    parameter int         ROWS        = 24,
    parameter int         TILE        = 20,
    parameter int         START_X     = 600,
    parameter int         START_Y     = 160,
    parameter logic [1:0] START_DIR   = 2'd0,
    parameter int         SCATTER_COL = 31,
    parameter int         SCATTER_ROW = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          step,
    input  logic [1:0]                    mode,
    input  logic [$clog2(COLS)-1:0]       target_col,
    input  logic [$clog2(ROWS)-1:0]       target_row,
    input  logic [ROWS*COLS-1:0]          tilemap_walls,
    output logic [$clog2(COLS*TILE)-1:0]  next_x,
    output logic [$clog2(ROWS*TILE)-1:0]  next_y,
    output logic [1:0]                    ghost_direction,
    output logic                          busy,
    output logic                          done
);

    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam int X_W   = $clog2(COLS*TILE);
    localparam int Y_W   = $clog2(ROWS*TILE);
    localparam int IDX_W = $clog2(ROWS*COLS);
    localparam int SC_W  = $clog2((COLS-1)*(COLS-1) + (ROWS-1)*(ROWS-1) + 1);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [1:0] MODE_CHASE   = 2'd0;
    localparam logic [1:0] MODE_SCATTER = 2'd1;
    localparam logic [1:0] MODE_FRIGHT  = 2'd2;
    localparam logic [1:0] MODE_HOME    = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PROBE0,
        S_PROBE1,
        S_PROBE2,
        S_PROBE3,
        S_DECIDE,
        S_MOVE
    } state_t;

    state_t            state;

    logic [1:0]        mode_lat;
    logic [1:0]        mode_prev;
    logic [COL_W-1:0]  tgt_col;
    logic [ROW_W-1:0]  tgt_row;

    logic              best_valid;
    logic [1:0]        best_dir;
    logic [SC_W-1:0]   best_score;
    logic              rev_open;

    logic [1:0]        dec_dir;
    logic              dec_move;

    logic [COL_W-1:0]  cur_col;
    logic [ROW_W-1:0]  cur_row;
    logic [COL_W-1:0]  eff_col;
    logic [ROW_W-1:0]  eff_row;

    logic [1:0]        rev_dir;
    logic [1:0]        probe_dir;
    logic              in_probe;
    logic              probe_open;
    logic              probe_is_rev;
    logic              probe_take;
    logic [SC_W-1:0]   probe_score;
    logic [IDX_W-1:0]  wall_idx;
    logic              nb_inside;
    int                nb_c;
    int                nb_r;
    int                dc;
    int                dr;

    logic              mode_flip;
    logic [1:0]        dec_dir_c;
    logic              dec_move_c;

`ifdef GHOST_FRIGHT_RANDOM_EN
    logic [7:0]        lfsr;
    logic [3:0]        open_mask;
    logic [1:0]        slot;
    logic [1:0]        rand_dir;
    logic              rand_found;
`endif

    // Tile coordinates of the current position and the reverse heading
    always_comb begin
        cur_col = COL_W'(next_x / TILE);
        cur_row = ROW_W'(next_y / TILE);
        rev_dir = {ghost_direction[1], ~ghost_direction[0]};
    end

    // Target tile implied by the mode presented with step
    always_comb begin
        eff_col = target_col;
        eff_row = target_row;
        case (mode)
            MODE_SCATTER, MODE_FRIGHT: begin
                eff_col = COL_W'(SCATTER_COL);
                eff_row = ROW_W'(SCATTER_ROW);
            end
            MODE_HOME: begin
                eff_col = COL_W'(START_X / TILE);
                eff_row = ROW_W'(START_Y / TILE);
            end
            default: begin
                eff_col = target_col;
                eff_row = target_row;
            end
        endcase
    end

    // Neighbour openness and distance score for the direction probed this cycle
    always_comb begin
        in_probe  = (state == S_PROBE0) || (state == S_PROBE1) ||
                    (state == S_PROBE2) || (state == S_PROBE3);
        case (state)
            S_PROBE1: probe_dir = DIR_LEFT;
            S_PROBE2: probe_dir = DIR_DOWN;
            S_PROBE3: probe_dir = DIR_RIGHT;
            default:  probe_dir = DIR_UP;
        endcase
        nb_c = int'(cur_col);
        nb_r = int'(cur_row);
        case (probe_dir)
            DIR_UP:   nb_r = nb_r - 1;
            DIR_DOWN: nb_r = nb_r + 1;
            DIR_LEFT: nb_c = nb_c - 1;
            default:  nb_c = nb_c + 1;
        endcase
        nb_inside = (nb_c >= 0) && (nb_c < COLS) && (nb_r >= 0) && (nb_r < ROWS);
        wall_idx  = '0;
        if (nb_inside) begin
            wall_idx = IDX_W'(nb_r * COLS + nb_c);
        end
        probe_open   = nb_inside && !tilemap_walls[wall_idx];
        probe_is_rev = (probe_dir == rev_dir);
        dc = nb_c - int'(tgt_col);
        dr = nb_r - int'(tgt_row);
        if (dc < 0) dc = -dc;
        if (dr < 0) dr = -dr;
        // Out-of-map neighbours are never taken, so truncation there is harmless
        probe_score = SC_W'(dc * dc + dr * dr);
        probe_take  = in_probe && !probe_is_rev && probe_open &&
                      (!best_valid || (probe_score < best_score));
    end

`ifdef GHOST_FRIGHT_RANDOM_EN
    // Free-running Fibonacci LFSR, taps 8,6,5,4
    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    // First open non-reverse slot at or after LFSR[1:0], wrapping in probe order
    always_comb begin
        rand_found = 1'b0;
        rand_dir   = DIR_UP;
        slot       = '0;
        for (int i = 3; i >= 0; i--) begin
            slot = lfsr[1:0] + 2'(i);
            if (open_mask[slot]) begin
                rand_found = 1'b1;
                rand_dir   = {slot[0], slot[1]};
            end
        end
    end
`endif

    // Final choice: a mode flip reverses first, then best score, then dead-end reverse
    always_comb begin
        mode_flip  = (mode_lat != mode_prev) &&
                     ((mode_lat  == MODE_CHASE) || (mode_lat  == MODE_SCATTER) ||
                      (mode_prev == MODE_CHASE) || (mode_prev == MODE_SCATTER));
        dec_dir_c  = ghost_direction;
        dec_move_c = 1'b0;
        if (mode_flip && rev_open) begin
            dec_dir_c  = rev_dir;
            dec_move_c = 1'b1;
        end
`ifdef GHOST_FRIGHT_RANDOM_EN
        else if ((mode_lat == MODE_FRIGHT) && rand_found) begin
            dec_dir_c  = rand_dir;
            dec_move_c = 1'b1;
        end
`endif
        else if (best_valid) begin
            dec_dir_c  = best_dir;
            dec_move_c = 1'b1;
        end else if (rev_open) begin
            dec_dir_c  = rev_dir;
            dec_move_c = 1'b1;
        end
    end

    // Sequencing FSM with registered position, direction, busy and done
    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= S_IDLE;
            next_x          <= X_W'(START_X);
            next_y          <= Y_W'(START_Y);
            ghost_direction <= START_DIR;
            busy            <= 1'b0;
            done            <= 1'b0;
            mode_lat        <= mode;
            mode_prev       <= mode;
            tgt_col         <= '0;
            tgt_row         <= '0;
            best_valid      <= 1'b0;
            best_dir        <= DIR_UP;
            best_score      <= '0;
            rev_open        <= 1'b0;
            dec_dir         <= START_DIR;
            dec_move        <= 1'b0;
`ifdef GHOST_FRIGHT_RANDOM_EN
            open_mask       <= '0;
`endif
        end else begin
            done <= 1'b0;

            if (probe_take) begin
                best_valid <= 1'b1;
                best_dir   <= probe_dir;
                best_score <= probe_score;
            end
            if (in_probe && probe_is_rev) begin
                rev_open <= probe_open;
            end
`ifdef GHOST_FRIGHT_RANDOM_EN
            if (in_probe) begin
                open_mask[{probe_dir[0], probe_dir[1]}] <= probe_open && !probe_is_rev;
            end
`endif

            case (state)
                S_IDLE: begin
                    if (step) begin
                        mode_lat   <= mode;
                        tgt_col    <= eff_col;
                        tgt_row    <= eff_row;
                        best_valid <= 1'b0;
                        rev_open   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_PROBE0;
                    end
                end
                S_PROBE0: state <= S_PROBE1;
                S_PROBE1: state <= S_PROBE2;
                S_PROBE2: state <= S_PROBE3;
                S_PROBE3: state <= S_DECIDE;
                S_DECIDE: begin
                    dec_dir   <= dec_dir_c;
                    dec_move  <= dec_move_c;
                    mode_prev <= mode_lat;
                    state     <= S_MOVE;
                end
                S_MOVE: begin
                    if (dec_move) begin
                        ghost_direction <= dec_dir;
                        case (dec_dir)
                            DIR_UP:   next_y <= next_y - Y_W'(TILE);
                            DIR_DOWN: next_y <= next_y + Y_W'(TILE);
                            DIR_LEFT: next_x <= next_x - X_W'(TILE);
                            default:  next_x <= next_x + X_W'(TILE);
                        endcase
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                    // The edge that commits the move is also the earliest
                    // one at which a new step is taken
                    if (step) begin
                        mode_lat   <= mode;
                        tgt_col    <= eff_col;
                        tgt_row    <= eff_row;
                        best_valid <= 1'b0;
                        rev_open   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_PROBE0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ghost_nav_ctrl.sv
// Bench for ghost_nav_ctrl: a tile-level reference model plus directed
// scenarios with literal expectations, then a randomized walk.
module tb_ghost_nav_ctrl;

    localparam int COLS = 32;
    localparam int ROWS = 24;
    localparam int TILE = 20;
    localparam int NW   = COLS * ROWS;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          step = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [4:0]    target_col = '0;
    logic [4:0]    target_row = '0;
    logic [NW-1:0] walls = '0;
    logic [9:0]    next_x;
    logic [8:0]    next_y;
    logic [1:0]    ghost_direction;
    logic          busy;
    logic          done;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 0;

    // Reference model state (tile units)
    int m_col, m_row, m_dir, m_prev, m_cnt;
    int l_mode, l_tc, l_tr;
    int m_busy, m_done;

    ghost_nav_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .step            (step),
        .mode            (mode),
        .target_col      (target_col),
        .target_row      (target_row),
        .tilemap_walls   (walls),
        .next_x          (next_x),
        .next_y          (next_y),
        .ghost_direction (ghost_direction),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int dcol(input int d);
        return (d == 2) ? -1 : (d == 3) ? 1 : 0;
    endfunction

    function automatic int drow(input int d);
        return (d == 0) ? -1 : (d == 1) ? 1 : 0;
    endfunction

    function automatic bit is_open(input int c, input int r);
        if (c < 0 || c >= COLS || r < 0 || r >= ROWS) return 0;
        return !walls[r * COLS + c];
    endfunction

    // One decision from the rules: reverse on flip, else best score, else dead-end reverse
    task automatic model_decide();
        int order[4] = '{0, 2, 1, 3};
        int rv, best, bs, nc, nr, s;
        bit rvo, flip;
        rv   = m_dir ^ 1;
        best = -1;
        bs   = 1 << 30;
        for (int k = 0; k < 4; k++) begin
            nc = m_col + dcol(order[k]);
            nr = m_row + drow(order[k]);
            if (order[k] != rv && is_open(nc, nr)) begin
                s = (nc - l_tc) * (nc - l_tc) + (nr - l_tr) * (nr - l_tr);
                if (s < bs) begin
                    bs   = s;
                    best = order[k];
                end
            end
        end
        rvo  = is_open(m_col + dcol(rv), m_row + drow(rv));
        flip = (l_mode != m_prev) && (l_mode < 2 || m_prev < 2);
        m_prev = l_mode;
        if (flip && rvo) best = rv;
        else if (best < 0 && rvo) best = rv;
        if (best >= 0) begin
            m_col = m_col + dcol(best);
            m_row = m_row + drow(best);
            m_dir = best;
        end
    endtask

    // Model: a decision takes six edges from acceptance to the move
    always @(posedge clk) begin
        if (!reset) begin
            m_col  = 30;
            m_row  = 8;
            m_dir  = 0;
            m_busy = 0;
            m_done = 0;
            m_cnt  = 0;
            m_prev = int'(mode);
        end else begin
            m_done = 0;
            if (m_cnt == 6) begin
                model_decide();
                m_done = 1;
                m_busy = 0;
                m_cnt  = 0;
            end else if (m_cnt > 0) begin
                m_cnt++;
            end
            if (m_cnt == 0 && step) begin
                l_mode = int'(mode);
                if (mode == 2'd0) begin
                    l_tc = int'(target_col);
                    l_tr = int'(target_row);
                end else if (mode == 2'd3) begin
                    l_tc = 30;
                    l_tr = 8;
                end else begin
                    l_tc = 31;
                    l_tr = 0;
                end
                m_busy = 1;
                m_cnt  = 1;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_x",    int'(next_x), m_col * TILE);
            check("cyc_y",    int'(next_y), m_row * TILE);
            check("cyc_dir",  int'(ghost_direction), m_dir);
            check("cyc_busy", int'(busy), m_busy);
            check("cyc_done", int'(done), m_done);
        end
    end

    task automatic wait_idle();
        for (int g = 0; g < 40 && m_cnt != 0; g++) @(negedge clk);
        if (m_cnt != 0) check("idle_timeout", int'(busy), 0);
    endtask

    task automatic wall_at(input int c, input int r);
        walls[r * COLS + c] = 1'b1;
    endtask

    // Step with literal expectations on latency and final position
    task automatic step_and_check(input string name, input int ex, input int ey, input int ed);
        wait_idle();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        check({name, "_busy"}, int'(busy), 1);
        repeat (5) @(negedge clk);
        check({name, "_early_done"}, int'(done), 0);
        @(negedge clk);
        check({name, "_done"}, int'(done), 1);
        check({name, "_x"}, int'(next_x), ex);
        check({name, "_y"}, int'(next_y), ey);
        check({name, "_dir"}, int'(ghost_direction), ed);
    endtask

    // Wall in every tile except the neighbour in direction d
    task automatic force_move(input int d);
        wait_idle();
        walls = '1;
        walls[(m_row + drow(d)) * COLS + (m_col + dcol(d))] = 1'b0;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int ndone;
        int m;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk_en = 1;
        check("rst_x", int'(next_x), 600);
        check("rst_y", int'(next_y), 160);
        check("rst_dir", int'(ghost_direction), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);

        // From (30,8) facing up toward (0,0): left 905 beats up 949
        walls = '0; mode = 2'd0; target_col = 5'd0; target_row = 5'd0;
        step_and_check("t1", 580, 160, 2);
        // From (29,8) facing left toward (29,0): up wins
        target_col = 5'd29;
        step_and_check("t1b", 580, 140, 0);

        // Walk to (10,10) arriving facing right
        for (int i = 0; i < 20; i++) force_move(2);
        for (int i = 0; i < 3; i++) force_move(1);
        force_move(3);
        walls = '0; wall_at(11, 10); wall_at(10, 9);
        target_col = 5'd15; target_row = 5'd15;
        step_and_check("t2", 200, 220, 1);

        // Walk to (5,5) arriving facing up, then dead end
        for (int i = 0; i < 5; i++) force_move(2);
        for (int i = 0; i < 6; i++) force_move(0);
        walls = '0; wall_at(5, 4); wall_at(4, 5); wall_at(6, 5);
        target_col = 5'd5; target_row = 5'd0;
        step_and_check("t3_dead", 100, 120, 1);
        walls = '0; wall_at(5, 5); wall_at(5, 7); wall_at(4, 6); wall_at(6, 6);
        step_and_check("t3_hold", 100, 120, 1);

        // Extra steps while busy are dropped
        wait_idle();
        walls = '0; target_col = 5'd5; target_row = 5'd23;
        ndone = 0;
        step = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done) ndone++;
            step = (i < 4);
        end
        step = 1'b0;
        check("t4_done_count", ndone, 1);
        check("t4_y", int'(next_y), 140);

        // Scatter leftward, then switch to chase: forced reversal
        mode = 2'd1;
        force_move(2);
        force_move(2);
        mode = 2'd0; walls = '0; target_col = 5'd0; target_row = 5'd7;
        step_and_check("t5", 80, 140, 3);

        // Reset sampled at N+3 aborts the decision
        wait_idle();
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("t6_x", int'(next_x), 600);
        check("t6_y", int'(next_y), 160);
        check("t6_busy", int'(busy), 0);
        ndone = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("t6_no_done", ndone, 0);

        // Randomized walk
        for (int t = 0; t < 250; t++) begin
            wait_idle();
            for (int i = 0; i < NW; i++) walls[i] = ($urandom_range(0, 3) == 0);
            m = $urandom_range(0, 2);
            mode = (m == 2) ? 2'd3 : 2'(m);
            target_col = 5'($urandom_range(0, COLS - 1));
            target_row = 5'($urandom_range(0, ROWS - 1));
            step = 1'b1;
            @(negedge clk);
            for (int g = 0; g < 8 && m_cnt != 6; g++) begin
                step = 1'($urandom_range(0, 1));
                m = $urandom_range(0, 2);
                mode = (m == 2) ? 2'd3 : 2'(m);
                target_col = 5'($urandom_range(0, COLS - 1));
                target_row = 5'($urandom_range(0, ROWS - 1));
                @(negedge clk);
            end
            step = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            step = 1'b0;
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
